// File: rtl/ann_mac_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// ann_pkg
// Shared definitions for the two-layer ANN MAC sequencer:
//   - state_t      : sequencer FSM state encoding (codes 5-7 unused)
//   - N_*_DEF      : default network geometry (30 inputs, 5 hidden, 3 outputs)
//   - OUT_W_BASE   : first weight address of the output layer for the
//                    default geometry; out_w_base() computes it for others.
// ---------------------------------------------------------------------------
package ann_pkg;

  localparam int N_IN_DEF  = 30;
  localparam int N_HID_DEF = 5;
  localparam int N_OUT_DEF = 3;

  localparam int OUT_W_BASE = N_IN_DEF * N_HID_DEF;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_CLR  = 3'd1,
    S_ACC  = 3'd2,
    S_ACT  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  // Output-layer weights start right after the hidden-layer weight block.
  function automatic int out_w_base(input int n_in, input int n_hid);
    return n_in * n_hid;
  endfunction

endpackage

// File: rtl/ann_mac_sequencer.sv
// ---------------------------------------------------------------------------
// ann_mac_sequencer
// Sequences one forward pass of a fully connected two-layer network over a
// single shared multiply-accumulate unit. For every neuron it clears the
// accumulator, streams fan-in operand/weight pairs, then applies activation.
//
// Ports
//   Clock      in   rising-edge clock
//   Rst        in   asynchronous active-low reset
//   Start      in   request a forward pass (only looked at in IDLE)
//   stall      in   freeze sequencing in any non-IDLE state
//   mac_clr    out  clear shared accumulator
//   mac_en     out  accumulate src[src_idx] * W[w_addr] this cycle
//   src_layer  out  0 = external inputs, 1 = hidden results
//   src_idx    out  operand index into the selected source
//   w_addr     out  weight memory address (neuron-major, contiguous)
//   act_en     out  apply activation and write result
//   dst_layer  out  0 = hidden register file, 1 = output register file
//   dst_idx    out  destination neuron index
//   busy       out  high in every state except IDLE
//   done       out  one-cycle pass-complete pulse
//   state      out  current FSM state code
// ---------------------------------------------------------------------------
module ann_mac_sequencer
  import ann_pkg::*;
#(
  parameter int N_IN   = N_IN_DEF,
  parameter int N_HID  = N_HID_DEF,
  parameter int N_OUT  = N_OUT_DEF,
  parameter int ADDR_W = 8
) (
  input  logic              Clock,
  input  logic              Rst,
  input  logic              Start,
  input  logic              stall,
  output logic              mac_clr,
  output logic              mac_en,
  output logic              src_layer,
  output logic [4:0]        src_idx,
  output logic [ADDR_W-1:0] w_addr,
  output logic              act_en,
  output logic              dst_layer,
  output logic [2:0]        dst_idx,
  output logic              busy,
  output logic              done,
  output logic [2:0]        state
);

  localparam logic [4:0]        LAST_OP_HID = 5'(N_IN - 1);
  localparam logic [4:0]        LAST_OP_OUT = 5'(N_HID - 1);
  localparam logic [2:0]        LAST_N_HID  = 3'(N_HID - 1);
  localparam logic [2:0]        LAST_N_OUT  = 3'(N_OUT - 1);
  localparam logic [ADDR_W-1:0] OUT_BASE    = ADDR_W'(out_w_base(N_IN, N_HID));

  state_t            state_q;
  logic              layer_q;
  logic [2:0]        neuron_q;
  logic [4:0]        operand_q;
  logic [ADDR_W-1:0] w_addr_q;
  logic              dst_layer_q;
  logic [2:0]        dst_idx_q;
  logic              hold;
  logic              last_op;

  // Stall only freezes the legal working states; stray codes still recover.
  assign hold    = stall && (state_q == S_CLR || state_q == S_ACC ||
                             state_q == S_ACT || state_q == S_DONE);
  assign last_op = (operand_q == (layer_q ? LAST_OP_OUT : LAST_OP_HID));

  always_ff @(posedge Clock or negedge Rst) begin
    if (!Rst) begin
      state_q     <= S_IDLE;
      layer_q     <= 1'b0;
      neuron_q    <= '0;
      operand_q   <= '0;
      w_addr_q    <= '0;
      dst_layer_q <= 1'b0;
      dst_idx_q   <= '0;
    end else if (!hold) begin
      case (state_q)
        S_IDLE: begin
          if (Start) begin
            state_q   <= S_CLR;
            layer_q   <= 1'b0;
            neuron_q  <= '0;
            operand_q <= '0;
            w_addr_q  <= '0;
          end
        end
        S_CLR: begin
          // Operand index keeps the previous neuron's last value during CLR
          // and only rewinds as ACC begins.
          operand_q <= '0;
          state_q   <= S_ACC;
        end
        S_ACC: begin
          w_addr_q <= w_addr_q + ADDR_W'(1);
          if (last_op) begin
            dst_layer_q <= layer_q;
            dst_idx_q   <= neuron_q;
            state_q     <= S_ACT;
          end else begin
            operand_q <= operand_q + 5'd1;
          end
        end
        S_ACT: begin
          if (!layer_q) begin
            state_q <= S_CLR;
            if (neuron_q == LAST_N_HID) begin
              layer_q  <= 1'b1;
              neuron_q <= '0;
              w_addr_q <= OUT_BASE;
            end else begin
              neuron_q <= neuron_q + 3'd1;
            end
          end else if (neuron_q == LAST_N_OUT) begin
            state_q <= S_DONE;
          end else begin
            neuron_q <= neuron_q + 3'd1;
            state_q  <= S_CLR;
          end
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Strobes are decoded from the registered state; stall masks them in the
  // same cycle so a frozen step never double-accumulates.
  assign mac_clr   = (state_q == S_CLR)  && !stall;
  assign mac_en    = (state_q == S_ACC)  && !stall;
  assign act_en    = (state_q == S_ACT)  && !stall;
  assign done      = (state_q == S_DONE) && !stall;
  assign busy      = (state_q != S_IDLE);
  assign state     = state_q;
  assign src_layer = layer_q;
  assign src_idx   = operand_q;
  assign w_addr    = w_addr_q;
  assign dst_layer = dst_layer_q;
  assign dst_idx   = dst_idx_q;

endmodule

// File: doc/ann_mac_sequencer.md
ANN_MAC_SEQUENCER -- requirements
Module: ann_mac_sequencer

Interface
REQ-001 SHALL have parameter N_IN, 30, fan-in of hidden layer (external inputs).
REQ-002 SHALL have parameter N_HID, 5, hidden neurons (also fan-in of output layer).
REQ-003 SHALL have parameter N_OUT, 3, output neurons.
REQ-004 SHALL have parameter ADDR_W, 8, weight-address width (≥ clog2(N_IN*N_HID+N_HID*N_OUT)).
REQ-005 SHALL have port Clock  input  1  single clock, all flops rising-edge.
REQ-006 SHALL have port Rst  input  1  asynchronous, active-low reset.
REQ-007 SHALL have port Start  input  1  request one forward pass; sampled only in IDLE.
REQ-008 SHALL have port stall  input  1  freeze sequencing (e.g. weight memory busy during training).
REQ-009 SHALL have port mac_clr  output  1  clear shared accumulator.
REQ-010 SHALL have port mac_en  output  1  accumulate src[src_idx]*W[w_addr] this cycle.
REQ-011 SHALL have port src_layer  output  1  0 = external input bus, 1 = hidden-result register file.
REQ-012 SHALL have port src_idx  output  5  operand index into selected source.
REQ-013 SHALL have port w_addr  output  ADDR_W  weight memory address.
REQ-014 SHALL have port act_en  output  1  apply activation and write result.
REQ-015 SHALL have port dst_layer  output  1  0 = hidden register file, 1 = output register file.
REQ-016 SHALL have port dst_idx  output  3  destination neuron index.
REQ-017 SHALL have port busy  output  1  high in every state except IDLE.
REQ-018 SHALL have port done  output  1  one-cycle pass-complete pulse.
REQ-019 SHALL have port state  output  3  current FSM state code.

Function
REQ-020 SHALL implement states IDLE=0, CLR=1, ACC=2, ACT=3, DONE=4; codes 5-7 SHALL return to IDLE next cycle.
REQ-021 IDLE: Start=1 at a rising edge SHALL move to CLR with layer=0, neuron=0, operand=0, w_addr=0.
REQ-022 CLR: mac_clr=1 for exactly one cycle, then ACC.
REQ-023 ACC: mac_en=1 each cycle; src_idx steps 0..fanin-1 (fanin = N_IN for layer 0, N_HID for layer 1); w_addr +1 per cycle; after operand fanin-1 go to ACT.
REQ-024 ACT: act_en=1 one cycle, dst_layer=layer, dst_idx=neuron; next: more neurons in layer -> CLR (neuron+1); last hidden neuron -> CLR with layer=1, neuron=0; last output neuron -> DONE.
REQ-025 w_addr SHALL be neuron-major and contiguous: hidden n,i -> n*N_IN+i (0..149); output m,j -> N_IN*N_HID+m*N_HID+j (150..164); it holds outside ACC.
REQ-026 src_layer SHALL equal layer; src_idx, dst_idx SHALL hold last value outside ACC/ACT.
REQ-027 DONE: done=1 one cycle, then IDLE.
REQ-028 Latency with defaults and no stall: done high in the 182nd cycle after the Start-sampling edge (160 hidden + 21 output cycles + DONE).
REQ-029 Start while busy SHALL be ignored (no queuing); Start held high in DONE-return IDLE SHALL launch a new pass.
REQ-030 stall=1 in any non-IDLE state SHALL hold state and all counters and force mac_clr, mac_en, act_en, done to 0; sequencing resumes unchanged on stall=0.
REQ-031 stall in IDLE SHALL not block Start.

Reset
REQ-032 Rst=0 SHALL immediately force IDLE, all counters 0, w_addr=0, src_layer=dst_layer=0, src_idx=dst_idx=0, all strobes, busy, done = 0, state=0.
REQ-033 Reset mid-pass SHALL abandon the pass; no done pulse; next Start restarts at w_addr 0.

Structure
REQ-034 Package ann_pkg SHALL hold the state enum, N_IN/N_HID/N_OUT defaults and the output-weight base offset constant.
REQ-035 No sub-module; FSM, operand/neuron counters and address counter SHALL be inline in ann_mac_sequencer.

Verification
REQ-036 Reset release, Start pulse one cycle -> mac_clr count 8, mac_en count 165, act_en count 8, done at cycle 182, busy high cycles 1..182.
REQ-037 Address trace -> w_addr sequence 0..164 each exactly once under mac_en; act_en dst pairs (0,0)..(0,4),(1,0)..(1,2) in order.
REQ-038 stall=1 for 10 cycles at ACC, hidden neuron 2, operand 17 -> strobes low, w_addr frozen at 77, done delayed to cycle 192.
REQ-039 Start pulsed at cycles 50 and 100 of a pass -> ignored, single done at 182; Start held high continuously -> second pass done at 182 cycles after first done's IDLE return.
REQ-040 Rst=0 at cycle 90 -> outputs zero asynchronously, no done; fresh Start -> full 182-cycle pass from w_addr 0.
